mpsoc_bridge_apb2ahb_master: RTL

APB4 slave to AHB3-Lite master bridge, the reverse direction of the existing AHB-slave/APB-master bridge in the UART subsystem. Lets an APB-only initiator (debug/config port, APB test master) reach AHB-Lite memory and peripherals. Each APB transfer becomes exactly one single AHB transfer. Single clock domain, no CDC.

---
 rtl/mpsoc_bridge_pkg.sv | 21 ++
 rtl/mpsoc_bridge_apb2ahb_master_if.sv | 45 ++++
 rtl/mpsoc_apb_strb2hsize.sv | 29 ++
 rtl/mpsoc_bridge_apb2ahb_master.sv | 130 +++++++++++++
 4 files changed

// File: rtl/mpsoc_bridge_pkg.sv
// Shared constants and FSM state type for the APB4-slave to AHB3-Lite-master bridge.
package mpsoc_bridge_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [2:0] HSIZE_BYTE  = 3'b000;
    localparam logic [2:0] HSIZE_HWORD = 3'b001;
    localparam logic [2:0] HSIZE_WORD  = 3'b010;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE_ERR,
        ST_ADDR,
        ST_DATA,
        ST_DONE
    } bridge_state_e;

endpackage

// File: rtl/mpsoc_bridge_apb2ahb_master_if.sv
// APB4 + AHB3-Lite signal bundle around the bridge.
// The master modport is the bridge's view (APB slave side, AHB master side);
// the slave modport is the surrounding system's view.
interface mpsoc_bridge_apb2ahb_master_if #(
    parameter int PADDR_SIZE = 16,
    parameter int HADDR_SIZE = 32
);
    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [PADDR_SIZE-1:0] PADDR;
    logic [31:0]           PWDATA;
    logic [3:0]            PSTRB;
    logic [2:0]            PPROT;
    logic [31:0]           PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    logic [HADDR_SIZE-1:0] HADDR;
    logic [31:0]           HWDATA;
    logic [31:0]           HRDATA;
    logic                  HWRITE;
    logic [2:0]            HSIZE;
    logic [2:0]            HBURST;
    logic [3:0]            HPROT;
    logic [1:0]            HTRANS;
    logic                  HMASTLOCK;
    logic                  HREADY;
    logic                  HRESP;

    modport master (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
        output PRDATA, PREADY, PSLVERR,
        output HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK,
        input  HRDATA, HREADY, HRESP
    );

    modport slave (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
        input  PRDATA, PREADY, PSLVERR,
        input  HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK,
        output HRDATA, HREADY, HRESP
    );

endinterface

// File: rtl/mpsoc_apb_strb2hsize.sv
// Maps an APB write strobe onto an AHB transfer size and starting byte lane.
// Only naturally aligned byte, halfword and word patterns are representable.
module mpsoc_apb_strb2hsize
    import mpsoc_bridge_pkg::*;
(
    input  logic [3:0] pstrb,
    output logic       legal,
    output logic [2:0] hsize,
    output logic [1:0] lane
);

    // Pure lookup; anything not listed cannot be expressed as one AHB transfer
    always_comb begin
        legal = 1'b1;
        hsize = HSIZE_BYTE;
        lane  = 2'd0;
        case (pstrb)
            4'b1111: hsize = HSIZE_WORD;
            4'b0011: hsize = HSIZE_HWORD;
            4'b1100: begin hsize = HSIZE_HWORD; lane = 2'd2; end
            4'b0001: lane = 2'd0;
            4'b0010: lane = 2'd1;
            4'b0100: lane = 2'd2;
            4'b1000: lane = 2'd3;
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/mpsoc_bridge_apb2ahb_master.sv
// APB4 slave to AHB3-Lite master bridge: each APB access becomes one SINGLE
// AHB transfer, with at most one transfer outstanding.
module mpsoc_bridge_apb2ahb_master
    import mpsoc_bridge_pkg::*;
#(
    parameter int                    PADDR_SIZE = 16,
    parameter int                    HADDR_SIZE = 32,
    parameter int                    DATA_SIZE  = 32,
    parameter logic [HADDR_SIZE-1:0] HADDR_BASE = '0
) (
    input logic                    CLK,
    input logic                    RST,
    mpsoc_bridge_apb2ahb_master_if.master bus
);

    bridge_state_e         state, next_state;
    logic                  setup;
    logic                  strb_legal;
    logic [2:0]            strb_hsize;
    logic [1:0]            strb_lane;
    logic                  req_legal;
    logic [2:0]            req_hsize;
    logic [1:0]            req_lane;
    logic [HADDR_SIZE-1:0] req_haddr;
    logic [1:0]            htrans;
    logic                  done_err;

    logic [HADDR_SIZE-1:0] haddr_q;
    logic [DATA_SIZE-1:0]  hwdata_q;
    logic [DATA_SIZE-1:0]  prdata_q;
    logic                  hwrite_q;
    logic [2:0]            hsize_q;
    logic [3:0]            hprot_q;
    logic                  pready_q;
    logic                  pslverr_q;

    assign setup = bus.PSEL & ~bus.PENABLE;

    mpsoc_apb_strb2hsize u_strb2hsize (
        .pstrb (bus.PSTRB),
        .legal (strb_legal),
        .hsize (strb_hsize),
        .lane  (strb_lane)
    );

    // Reads always fetch the whole word; writes take size and lane from the strobe
    always_comb begin
        req_legal = 1'b1;
        req_hsize = HSIZE_WORD;
        req_lane  = 2'd0;
        if (bus.PWRITE) begin
            req_legal = strb_legal;
            req_hsize = strb_hsize;
            req_lane  = strb_lane;
        end
    end

    assign req_haddr = HADDR_BASE + HADDR_SIZE'({bus.PADDR[PADDR_SIZE-1:2], req_lane});

    // State register
    always_ff @(posedge CLK) begin
        if (RST) state <= ST_IDLE;
        else     state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:       if (setup) next_state = req_legal ? ST_ADDR : ST_DECODE_ERR;
            ST_DECODE_ERR: next_state = ST_DONE;
            ST_ADDR:       if (bus.HREADY) next_state = ST_DATA;
            ST_DATA:       if (bus.HREADY) next_state = ST_DONE;
            ST_DONE:       next_state = ST_IDLE;
            default:       next_state = ST_IDLE;
        endcase
    end

    // State-decoded outputs: NONSEQ only in the address phase, error flag for the completion
    always_comb begin
        htrans   = HTRANS_IDLE;
        done_err = 1'b0;
        case (state)
            ST_ADDR:       htrans   = HTRANS_NONSEQ;
            ST_DATA:       done_err = bus.HRESP;
            ST_DECODE_ERR: done_err = 1'b1;
            default:       ;
        endcase
    end

    // Request capture at setup, read-data capture on OKAY, registered APB completion
    always_ff @(posedge CLK) begin
        if (RST) begin
            haddr_q   <= '0;
            hwdata_q  <= '0;
            hwrite_q  <= 1'b0;
            hsize_q   <= 3'b000;
            hprot_q   <= 4'b0000;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
        end else begin
            if (state == ST_IDLE && setup) begin
                haddr_q  <= req_haddr;
                hwdata_q <= bus.PWDATA;
                hwrite_q <= bus.PWRITE;
                hsize_q  <= req_hsize;
                hprot_q  <= {2'b00, bus.PPROT[0], ~bus.PPROT[2]};
            end
            if (state == ST_DATA && bus.HREADY && !bus.HRESP && !hwrite_q) begin
                prdata_q <= bus.HRDATA;
            end
            pready_q  <= (next_state == ST_DONE);
            pslverr_q <= (next_state == ST_DONE) && done_err;
        end
    end

    assign bus.HTRANS    = htrans;
    assign bus.HADDR     = haddr_q;
    assign bus.HWDATA    = hwdata_q;
    assign bus.HWRITE    = hwrite_q;
    assign bus.HSIZE     = hsize_q;
    assign bus.HPROT     = hprot_q;
    assign bus.HBURST    = HBURST_SINGLE;
    assign bus.HMASTLOCK = 1'b0;
    assign bus.PRDATA    = prdata_q;
    assign bus.PREADY    = pready_q;
    assign bus.PSLVERR   = pslverr_q;

endmodule
